star_extent_scanner: RTL and testbench

- Parametrised successor to the star edge-tracing datapath/controller pair.
- Given a seed pixel known to lie on a star, finds all four extents of the star in a frame buffer of configurable size and colour depth: right, left, bottom and top.
- Walks rows and columns through a read port with one-cycle latency.
- Sits between the star-detect scan and the star-centring/marking logic, and uses a start/done handshake.

---
 rtl/star_extent_scanner.sv | 139 +++++++++++++
 tb/tb_star_extent_scanner.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/star_extent_scanner.sv
// star_extent_scanner: from a bright seed pixel, walks right/left along the seed row,
// then down/up along the midpoint column, reporting the star's bright extents.
module star_extent_scanner #(
  parameter int WIDTH = 160,
  parameter int HEIGHT = 120,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int ADDR_W = 15,
  parameter int COL_W = 3,
  parameter int THRESHOLD = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [X_W-1:0]    x_in,
  input  logic [Y_W-1:0]    y_in,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [COL_W-1:0]  mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              seed_bad,
  output logic [X_W-1:0]    left_x,
  output logic [X_W-1:0]    right_x,
  output logic [X_W-1:0]    mid_x,
  output logic [Y_W-1:0]    top_y,
  output logic [Y_W-1:0]    bottom_y
);
  typedef enum logic [2:0] {IDLE, SEED, RIGHT, LEFT, DOWN, UP, FIN} scanState;
  localparam logic [X_W-1:0] xMax = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] yMax = Y_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] thr = COL_W'(THRESHOLD);
  scanState state, nState, tryS;
  logic phase, nPhase, bad, nBad, bright;
  logic [X_W-1:0] seedX, nSeedX, rW, rN, lW, lN, midN;
  logic [Y_W-1:0] seedY, nSeedY, bW, bN, tW, tN;
  logic [X_W:0] midSum;
  logic [ADDR_W-1:0] nAddr;

  function automatic logic [ADDR_W-1:0] addrOf(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(WIDTH) + ADDR_W'(x);
  endfunction

  function automatic logic inRange(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return int'(x) < WIDTH && int'(y) < HEIGHT;
  endfunction

  assign bright = mem_rdata > thr;
  assign busy = state != IDLE;

  // phase 0 is the issue cycle, phase 1 the check cycle; skipped probes cost no cycles
  always_comb begin
    nState = state;
    nPhase = 1'b1;
    nBad = bad;
    nSeedX = seedX;
    nSeedY = seedY;
    nAddr = mem_addr;
    tryS = FIN;
    rN = (state == RIGHT && phase && bright) ? rW + X_W'(1) : rW;
    lN = (state == LEFT && phase && bright) ? lW - X_W'(1) : lW;
    bN = (state == DOWN && phase && bright) ? bW + Y_W'(1) : bW;
    tN = (state == UP && phase && bright) ? tW - Y_W'(1) : tW;
    midSum = {1'b0, lN} + {1'b0, rN};
    midN = X_W'(midSum >> 1);
    if (state == IDLE) begin
      nPhase = 1'b0;
      if (start) begin
        nState = SEED;
        nSeedX = x_in;
        nSeedY = y_in;
        rN = x_in;
        lN = x_in;
        bN = y_in;
        tN = y_in;
        nBad = 1'b0;
        nAddr = inRange(x_in, y_in) ? addrOf(x_in, y_in) : mem_addr;
      end
    end else if (state == FIN) begin
      nState = IDLE;
    end else if (state == SEED && !phase && !inRange(seedX, seedY)) begin
      nState = FIN;
      nBad = 1'b1;
    end else if (phase) begin
      nBad = state == SEED && !bright;
      tryS = bright ? (state == SEED ? RIGHT : state) : (state == SEED ? FIN : scanState'(state + 3'd1));
      if (tryS == RIGHT && rN == xMax) tryS = LEFT;
      if (tryS == LEFT && lN == '0) tryS = DOWN;
      if (tryS == DOWN && bN == yMax) tryS = UP;
      if (tryS == UP && tN == '0) tryS = FIN;
      nState = tryS;
      nPhase = 1'b0;
      nAddr = tryS == RIGHT ? addrOf(rN + X_W'(1), seedY) :
              tryS == LEFT  ? addrOf(lN - X_W'(1), seedY) :
              tryS == DOWN  ? addrOf(midN, bN + Y_W'(1)) :
              tryS == UP    ? addrOf(midN, tN - Y_W'(1)) : mem_addr;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      phase <= 1'b0;
      bad <= 1'b0;
      seedX <= '0;
      seedY <= '0;
      rW <= '0;
      lW <= '0;
      bW <= '0;
      tW <= '0;
      mem_addr <= '0;
      done <= 1'b0;
      seed_bad <= 1'b0;
      left_x <= '0;
      right_x <= '0;
      mid_x <= '0;
      top_y <= '0;
      bottom_y <= '0;
    end else begin
      state <= nState;
      phase <= nPhase;
      bad <= nBad;
      seedX <= nSeedX;
      seedY <= nSeedY;
      rW <= rN;
      lW <= lN;
      bW <= bN;
      tW <= tN;
      mem_addr <= nAddr;
      done <= state == FIN;
      if (state == FIN) begin
        seed_bad <= bad;
        left_x <= lW;
        right_x <= rW;
        mid_x <= midN;
        top_y <= tW;
        bottom_y <= bW;
      end
    end
endmodule

// File: tb/tb_star_extent_scanner.sv
// tb_star_extent_scanner: directed scans over a modelled 160x120 frame buffer with
// hand-computed extents and start-to-done latencies.
module tb_star_extent_scanner;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic [7:0] x_in = '0;
  logic [6:0] y_in = '0;
  logic [14:0] mem_addr;
  logic [2:0] mem_rdata = '0;
  logic busy, done, seed_bad;
  logic [7:0] left_x, right_x, mid_x;
  logic [6:0] top_y, bottom_y;
  logic [2:0] frame [0:19199];
  int nChecks = 0;
  int nBad = 0;
  int cyc;
  int maxA;
  logic hit160, moved, midBusy;
  logic [7:0] midLeft;

  star_extent_scanner dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy), .done(done),
    .seed_bad(seed_bad), .left_x(left_x), .right_x(right_x), .mid_x(mid_x),
    .top_y(top_y), .bottom_y(bottom_y)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= (mem_addr < 15'd19200) ? frame[mem_addr] : 3'd0;

  task automatic clearFrame();
    for (int i = 0; i < 19200; i++) frame[i] = 3'd0;
  endtask

  task automatic setRect(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++) frame[y * 160 + x] = 3'd5;
  endtask

  task automatic runScan(input logic [7:0] x, input logic [6:0] y);
    logic [14:0] a0;
    @(negedge clk);
    a0 = mem_addr;
    x_in = x;
    y_in = y;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    maxA = int'(mem_addr);
    hit160 = mem_addr == 15'd160;
    moved = mem_addr != a0;
    while (cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
      if (int'(mem_addr) > maxA) maxA = int'(mem_addr);
      if (mem_addr == 15'd160) hit160 = 1'b1;
      if (mem_addr != a0) moved = 1'b1;
      if (cyc == 4) begin
        midLeft = left_x;
        midBusy = busy;
      end
      if (done) break;
    end
    nChecks++;
    if (done !== 1'b1) begin
      nBad++;
      $display("FAIL scan_timeout: done=%b after %0d cycles, required 1", done, cyc);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if ({busy, done, seed_bad, mem_addr, left_x, right_x, mid_x, top_y, bottom_y} !== '0) begin
      nBad++;
      $display("FAIL reset_outputs: busy=%b done=%b bad=%b addr=%0d l=%0d r=%0d m=%0d t=%0d b=%0d, required all 0",
               busy, done, seed_bad, mem_addr, left_x, right_x, mid_x, top_y, bottom_y);
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_single();
    clearFrame();
    frame[20 * 160 + 10] = 3'd7;
    runScan(8'd10, 7'd20);
    nChecks++;
    if (cyc !== 11) begin nBad++; $display("FAIL single_latency: got %0d required 11", cyc); end
    nChecks++;
    if ({left_x, right_x, mid_x} !== {8'd10, 8'd10, 8'd10}) begin
      nBad++; $display("FAIL single_x: l=%0d r=%0d m=%0d required 10 10 10", left_x, right_x, mid_x);
    end
    nChecks++;
    if ({top_y, bottom_y, seed_bad} !== {7'd20, 7'd20, 1'b0}) begin
      nBad++; $display("FAIL single_y: t=%0d b=%0d bad=%b required 20 20 0", top_y, bottom_y, seed_bad);
    end
  endtask

  task automatic test_rect();
    clearFrame();
    setRect(5, 9, 3, 6);
    runScan(8'd5, 7'd3);
    nChecks++;
    if ({midBusy, midLeft} !== {1'b1, 8'd10}) begin
      nBad++; $display("FAIL rect_midscan_hold: busy=%b left=%0d required 1 10", midBusy, midLeft);
    end
    nChecks++;
    if (cyc !== 25) begin nBad++; $display("FAIL rect_latency: got %0d required 25", cyc); end
    nChecks++;
    if ({left_x, right_x, mid_x} !== {8'd5, 8'd9, 8'd7}) begin
      nBad++; $display("FAIL rect_x: l=%0d r=%0d m=%0d required 5 9 7", left_x, right_x, mid_x);
    end
    nChecks++;
    if ({top_y, bottom_y, seed_bad} !== {7'd3, 7'd6, 1'b0}) begin
      nBad++; $display("FAIL rect_y: t=%0d b=%0d bad=%b required 3 6 0", top_y, bottom_y, seed_bad);
    end
  endtask

  task automatic test_corner();
    clearFrame();
    setRect(150, 159, 0, 0);
    setRect(154, 154, 0, 3);
    runScan(8'd159, 7'd0);
    nChecks++;
    if (cyc !== 31) begin nBad++; $display("FAIL corner_latency: got %0d required 31", cyc); end
    nChecks++;
    if ({left_x, right_x, mid_x} !== {8'd150, 8'd159, 8'd154}) begin
      nBad++; $display("FAIL corner_x: l=%0d r=%0d m=%0d required 150 159 154", left_x, right_x, mid_x);
    end
    nChecks++;
    if ({top_y, bottom_y} !== {7'd0, 7'd3}) begin
      nBad++; $display("FAIL corner_y: t=%0d b=%0d required 0 3", top_y, bottom_y);
    end
    nChecks++;
    if (maxA > 19199 || hit160) begin
      nBad++; $display("FAIL corner_addr: max=%0d beyond_right=%b required max<=19199 and 0", maxA, hit160);
    end
  endtask

  task automatic test_dark();
    clearFrame();
    runScan(8'd40, 7'd40);
    nChecks++;
    if (cyc !== 3) begin nBad++; $display("FAIL dark_latency: got %0d required 3", cyc); end
    nChecks++;
    if ({seed_bad, left_x, right_x, mid_x, top_y, bottom_y} !== {1'b1, 8'd40, 8'd40, 8'd40, 7'd40, 7'd40}) begin
      nBad++; $display("FAIL dark_result: bad=%b l=%0d r=%0d m=%0d t=%0d b=%0d required 1 and all 40",
                       seed_bad, left_x, right_x, mid_x, top_y, bottom_y);
    end
  endtask

  task automatic test_out_of_range();
    runScan(8'd160, 7'd5);
    nChecks++;
    if (cyc !== 2) begin nBad++; $display("FAIL oob_latency: got %0d required 2", cyc); end
    nChecks++;
    if ({seed_bad, moved} !== 2'b10) begin
      nBad++; $display("FAIL oob_result: bad=%b addr_moved=%b required 1 0", seed_bad, moved);
    end
  endtask

  task automatic test_abort_restart();
    int dones;
    int doneAt;
    clearFrame();
    setRect(5, 9, 3, 6);
    @(negedge clk);
    x_in = 8'd5;
    y_in = 7'd3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    nChecks++;
    if ({busy, done} !== 2'b00) begin
      nBad++; $display("FAIL abort_immediate: busy=%b done=%b required 0 0", busy, done);
    end
    @(negedge clk) reset = 1'b0;
    nChecks++;
    if ({left_x, mid_x, mem_addr} !== '0) begin
      nBad++; $display("FAIL abort_cleared: l=%0d m=%0d addr=%0d required 0 0 0", left_x, mid_x, mem_addr);
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    doneAt = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 6) start = 1'b1;
      if (c == 7) start = 1'b0;
      if (done) begin
        dones++;
        if (doneAt < 0) doneAt = c;
      end
    end
    nChecks++;
    if (dones !== 1 || doneAt !== 25) begin
      nBad++; $display("FAIL restart_done: pulses=%0d first_at=%0d required 1 at 25", dones, doneAt);
    end
    nChecks++;
    if ({left_x, right_x, mid_x, top_y, bottom_y} !== {8'd5, 8'd9, 8'd7, 7'd3, 7'd6}) begin
      nBad++; $display("FAIL restart_result: l=%0d r=%0d m=%0d t=%0d b=%0d required 5 9 7 3 6",
                       left_x, right_x, mid_x, top_y, bottom_y);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rect();
    test_corner();
    test_dark();
    test_out_of_range();
    test_abort_restart();
    $display("test done: total=%0d bad=%0d", nChecks, nBad);
    $finish;
  end
endmodule
